// File: rtl/demux_1_2.sv
// Registered 1:2 demultiplexer: steers Data_In to one of two output registers;
// the unselected port, and both ports when disabled or in reset, load zero.
module demux_1_2 #(
   parameter int unsigned DATA_WIDTH = 1
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   input  logic                  Enable_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Select_In,
   output logic [DATA_WIDTH-1:0] Data_0_Out,
   output logic [DATA_WIDTH-1:0] Data_1_Out
);

   logic [DATA_WIDTH-1:0] data_0_nxt_c;
   logic [DATA_WIDTH-1:0] data_1_nxt_c;

   // Steering: only the selected port sees data, the other reloads zero.
   always_comb begin
      data_0_nxt_c = '0;
      data_1_nxt_c = '0;
      if (Enable_In) begin
         if (Select_In) data_1_nxt_c = Data_In;
         else           data_0_nxt_c = Data_In;
      end
   end

   // Output registers, reloaded every cycle so no stale word is held.
   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         Data_0_Out <= '0;
         Data_1_Out <= '0;
      end else begin
         Data_0_Out <= data_0_nxt_c;
         Data_1_Out <= data_1_nxt_c;
      end
   end

endmodule

// File: tb/tb_demux_1_2.sv
// Bench for demux_1_2: directed scenarios plus randomized routing, checked
// against a one-cycle-delayed reference of the routing rule at widths 1 and 8.
module tb_demux_1_2;

   localparam int unsigned W8 = 8;

   logic          clk;
   logic          rst;
   logic          en;
   logic          sel;
   logic [0:0]    din1;
   logic [W8-1:0] din8;
   logic [0:0]    q0_1, q1_1;
   logic [W8-1:0] q0_8, q1_8;

   int n_compared;
   int n_mismatched;

   demux_1_2 #(.DATA_WIDTH(1)) u_dut1 (
      .Clock_In   (clk),
      .Reset_In   (rst),
      .Enable_In  (en),
      .Data_In    (din1),
      .Select_In  (sel),
      .Data_0_Out (q0_1),
      .Data_1_Out (q1_1)
   );

   demux_1_2 #(.DATA_WIDTH(W8)) u_dut8 (
      .Clock_In   (clk),
      .Reset_In   (rst),
      .Enable_In  (en),
      .Data_In    (din8),
      .Select_In  (sel),
      .Data_0_Out (q0_8),
      .Data_1_Out (q1_8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a port carries the word only when out of reset, enabled and selected.
   function automatic logic [31:0] ref_port(input logic r, input logic e, input logic s,
                                            input logic [31:0] d, input int port);
      if (r || !e) return 32'd0;
      return (int'(s) == port) ? d : 32'd0;
   endfunction

   logic [31:0] e0_1, e1_1, e0_8, e1_8;

   // Apply one input set, clock it in, then check both widths after the edge.
   task automatic step(input string tag, input logic r, input logic e, input logic s,
                       input logic [0:0] d1, input logic [W8-1:0] d8);
      rst  = r;
      en   = e;
      sel  = s;
      din1 = d1;
      din8 = d8;
      @(posedge clk);
      #1;
      e0_1 = ref_port(r, e, s, 32'(d1), 0);
      e1_1 = ref_port(r, e, s, 32'(d1), 1);
      e0_8 = ref_port(r, e, s, 32'(d8), 0);
      e1_8 = ref_port(r, e, s, 32'(d8), 1);
      check({tag, " w1 port0"}, 32'(q0_1), e0_1);
      check({tag, " w1 port1"}, 32'(q1_1), e1_1);
      check({tag, " w8 port0"}, 32'(q0_8), e0_8);
      check({tag, " w8 port1"}, 32'(q1_8), e1_8);
      check({tag, " w8 onehot"}, 32'((q0_8 != '0) && (q1_8 != '0)), 32'd0);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst  = 1'b0;
      en   = 1'b0;
      sel  = 1'b0;
      din1 = '0;
      din8 = '0;

      step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);

      step("disabled sel0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
      step("disabled sel1", 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);

      step("route 1,0", 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
      step("route 1,1", 1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
      step("route 0,0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step("route 0,1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      step("toggle a", 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
      step("toggle b", 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
      step("toggle c", 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);

      step("midrst pre",  1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
      step("midrst rst",  1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
      step("midrst post", 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
      check("midrst port1 3C", 32'(q1_8), 32'h3C);

      step("enable drop", 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);

      step("rand lead disabled", 1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      for (int i = 0; i < 10; i++) begin
         step($sformatf("rand %0d", i), 1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
         // Inputs moving between edges must not disturb the registered outputs.
         sel  = ~sel;
         din8 = ~din8;
         din1 = ~din1;
         #3;
         check($sformatf("rand %0d hold p0", i), 32'(q0_8), e0_8);
         check($sformatf("rand %0d hold p1", i), 32'(q1_8), e1_8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/demux_1_2.md
# demux_1_2

Registered 1:2 demultiplexer. Routes one input data word to one of two output ports selected by `Select_In`, gated by `Enable_In`. The non-selected output, and both outputs when disabled, are driven to zero. Used as a leaf steering element wherever a single source feeds one of two consumers; the outputs are registered so they can drive downstream logic directly.

## Interface
- `DATA_WIDTH`, default 1, width of `Data_In`, `Data_0_Out` and `Data_1_Out`; legal range ≥ 1.
- `Clock_In` input 1: single clock; all state updates on its rising edge.
- `Reset_In` input 1: reset, synchronous, active-high.
- `Enable_In` input 1: 1 = route data; 0 = both outputs forced to zero.
- `Data_In` input `DATA_WIDTH`: data word to be routed.
- `Select_In` input 1: 0 = route to `Data_0_Out`; 1 = route to `Data_1_Out`.
- `Data_0_Out` output `DATA_WIDTH`: registered output port 0.
- `Data_1_Out` output `DATA_WIDTH`: registered output port 1.

## Operation
- No state machine. Each output is a `DATA_WIDTH` register loaded every cycle.
- Next-state function, evaluated at each rising edge of `Clock_In`, in priority order:
  - `Reset_In`=1: `Data_0_Out` = 0, `Data_1_Out` = 0.
  - `Enable_In`=0: `Data_0_Out` = 0, `Data_1_Out` = 0.
  - `Enable_In`=1, `Select_In`=0: `Data_0_Out` = `Data_In`, `Data_1_Out` = 0.
  - `Enable_In`=1, `Select_In`=1: `Data_0_Out` = 0, `Data_1_Out` = `Data_In`.
- Outputs never hold stale data. A port not selected in a cycle reads zero in the following cycle.
- At most one output is non-zero at any time. Both are zero whenever the routed data is zero.
- No width conversion: `Data_In` bits map one-to-one onto the selected output.
- No handshake. The block accepts a new word every cycle with no backpressure.

## Timing
- Latency: exactly 1 clock cycle from input sample to output.
  - Inputs sampled at edge N are visible on the outputs after edge N.
  - Outputs hold until edge N+1.
- Throughput: 1 word per cycle. Back-to-back select toggling is legal every cycle.
- Reset value: `Data_0_Out` = 0 and `Data_1_Out` = 0 after the first rising edge with `Reset_In`=1.
  - Before the first clock edge the outputs are undefined.
- Reset mid-stream: reset has priority over `Enable_In`/`Select_In`.
  - Outputs are zero the cycle after reset is sampled, regardless of the other inputs.
  - Normal routing resumes on the first edge with `Reset_In`=0.
- Enable deassertion takes effect on the next edge. The last routed word is not retained.
- `Select_In` or `Enable_In` changing between edges has no effect until sampled. Outputs are glitch-free (register-driven).

## Test plan
- Reset: drive `Reset_In`=1, `Enable_In`=1, `Select_In`=1, `Data_In`=1 for one edge -> after edge `Data_0_Out`=0, `Data_1_Out`=0.
- Disabled: `Reset_In`=0, `Enable_In`=0, `Data_In`=1, `Select_In`=0 then 1 -> both outputs 0 every cycle.
- Routing, `DATA_WIDTH`=1, `Enable_In`=1:
  - (`Data_In`,`Select_In`)=(1,0) -> next cycle `Data_0_Out`=1, `Data_1_Out`=0.
  - (1,1) -> `Data_0_Out`=0, `Data_1_Out`=1.
  - (0,x) -> both 0.
- Toggle and width: `DATA_WIDTH`=8, `Enable_In`=1, `Data_In`=8'hA5, `Select_In` alternating 0,1,0 on consecutive edges -> `Data_0_Out` sequence A5,00,A5 and `Data_1_Out` sequence 00,A5,00, each one cycle delayed.
- Mid-stream reset: routing 8'h3C to port 1, assert `Reset_In` for one edge, then release -> outputs 00/00 for that cycle, then `Data_1_Out`=3C the cycle after release.
- Random: 10 cycles of `Enable_In`=1 with random `Data_In`/`Select_In` after 1 disabled cycle -> scoreboard checks each output against the one-cycle-delayed reference function above, with both outputs never non-zero together.
